// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO: syncs the receiver ready level, pushes on its
// rising edge, FWFT read port, sticky overflow flag.
// Ports: i_clk/i_rst, i_rx_data/i_rx_ready in, i_rd/i_clr_ovf in,
//        o_data/o_valid/o_full/o_count/o_overflow out.
module uart_rx_fifo #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_ready,
  input  logic          i_rd,
  input  logic          i_clr_ovf,
  output logic [7:0]    o_data,
  output logic          o_valid,
  output logic          o_full,
  output logic [AW:0]   o_count,
  output logic          o_overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ready_s;
  logic                   ready_d;
  logic                   push_evt;
  logic                   push_ok;
  logic                   pop;
  logic                   drop;
  logic [7:0]             mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;

  assign ready_s  = sync_q[SYNC_STAGES-1];
  assign push_evt = ready_s & ~ready_d;

  assign o_count = count;
  assign o_valid = (count != '0);
  assign o_full  = (count == FULL_CNT);
  assign o_data  = o_valid ? mem[rd_ptr] : 8'h00;

  assign pop = i_rd & o_valid;

  // A pop frees the slot this cycle, so a push into a full FIFO proceeds.
  assign push_ok = push_evt & (~o_full | pop);
  assign drop    = push_evt & o_full & ~pop;

  // Flops reset to 1 so a receiver idling with ready high at reset
  // release does not look like a fresh edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q  <= '1;
      ready_d <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], i_rx_ready};
      ready_d <= ready_s;
    end
  end

  // Data is taken unsynchronized; the receiver holds it for a full baud.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= i_rx_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Set wins over clear.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_overflow <= 1'b0;
    end else if (drop) begin
      o_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      o_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed byte stimulus, queue scoreboard,
// negedge monitor checks popped data and occupancy.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rd;
  logic       clr_ovf;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_full;
  logic [4:0] o_count;
  logic       o_overflow;

  int checks;
  int failures;
  bit cnt_chk;
  bit send_done;
  logic [7:0] q [$];

  uart_rx_fifo #(
    .DEPTH(16),
    .AW(4),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx_data(rx_data),
    .i_rx_ready(rx_ready),
    .i_rd(rd),
    .i_clr_ovf(clr_ovf),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_full(o_full),
    .o_count(o_count),
    .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: occupancy against scoreboard, popped byte against head.
  always @(negedge clk) begin
    if (cnt_chk) begin
      check("count", 32'(o_count), 32'(q.size()));
    end
    if (rd && o_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got %0h expected none", o_data);
      end else begin
        check("pop_data", 32'(o_data), 32'(q.pop_front()));
      end
    end
  end

  // One ready low/high cycle; the byte lands on the third edge after the rise.
  task automatic send_byte(input logic [7:0] d,
                           input bit accept,
                           input bit rd_w,
                           input bit clr_w);
    @(posedge clk); #1;
    rx_ready = 1'b0;
    @(posedge clk); #1;
    rx_data  = d;
    rx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (rd_w)  rd = 1'b1;
    if (clr_w) clr_ovf = 1'b1;
    @(posedge clk); #1;
    if (rd_w)  rd = 1'b0;
    if (clr_w) clr_ovf = 1'b0;
    if (accept) q.push_back(d);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    rd = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (!o_valid) begin
        ok = 1'b1;
        break;
      end
    end
    rd = 1'b0;
    check("drain_done", 32'(ok), 32'd1);
    check("empty_data", 32'(o_data), 32'h00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    failures  = 0;
    cnt_chk   = 1'b0;
    send_done = 1'b0;
    rst       = 1'b0;
    rx_data   = 8'h00;
    rx_ready  = 1'b1;
    rd        = 1'b0;
    clr_ovf   = 1'b0;

    // Reset state, ready held high through release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_full", 32'(o_full), 32'd0);
    check("rst_data", 32'(o_data), 32'h00);
    check("rst_ovf", 32'(o_overflow), 32'd0);
    rst     = 1'b1;
    cnt_chk = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_valid", 32'(o_valid), 32'd0);
    check("idle_count", 32'(o_count), 32'd0);

    // Single byte, exact latency.
    rx_ready = 1'b0;
    @(posedge clk); #1;
    rx_data  = 8'hA5;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    check("lat_e1", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_e2", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_e3", 32'(o_valid), 32'd1);
    q.push_back(8'hA5);
    check("one_data", 32'(o_data), 32'hA5);
    check("one_count", 32'(o_count), 32'd1);
    rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    check("one_valid", 32'(o_valid), 32'd0);
    check("one_empty", 32'(o_data), 32'h00);

    // Fill, overflow drop, drain in order.
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), 1'b1, 1'b0, 1'b0);
    end
    check("fill_full", 32'(o_full), 32'd1);
    check("fill_count", 32'(o_count), 32'd16);
    check("fill_ovf", 32'(o_overflow), 32'd0);
    send_byte(8'hFF, 1'b0, 1'b0, 1'b0);
    check("drop_ovf", 32'(o_overflow), 32'd1);
    check("drop_count", 32'(o_count), 32'd16);
    drain();
    @(posedge clk); #1;
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    check("clr1_ovf", 32'(o_overflow), 32'd0);

    // Full with push and pop together, then clear racing a drop.
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
    end
    send_byte(8'h55, 1'b1, 1'b1, 1'b0);
    check("pp_count", 32'(o_count), 32'd16);
    check("pp_ovf", 32'(o_overflow), 32'd0);
    send_byte(8'h66, 1'b0, 1'b0, 1'b1);
    check("setwin_ovf", 32'(o_overflow), 32'd1);
    @(posedge clk); #1;
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    check("clr2_ovf", 32'(o_overflow), 32'd0);
    drain();

    // Pointer wrap with interleaved random-rate reads.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          for (int w = 0; w < 500 && q.size() >= 12; w++) begin
            @(posedge clk);
          end
          send_byte(8'(i * 7 + 3), 1'b1, 1'b0, 1'b0);
        end
        send_done = 1'b1;
      end
      begin
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 4000; n++) begin
          @(posedge clk); #1;
          if (send_done && q.size() == 0) begin
            ok = 1'b1;
            break;
          end
          rd = ($urandom_range(0, 2) == 0);
        end
        rd = 1'b0;
        check("wrap_done", 32'(ok), 32'd1);
      end
    join
    @(posedge clk); #1;
    check("wrap_count", 32'(o_count), 32'd0);

    // Reset mid-stream with an edge inside the synchronizer.
    for (int i = 0; i < 5; i++) begin
      send_byte(8'hC0 + 8'(i), 1'b1, 1'b0, 1'b0);
    end
    check("pre_rst_cnt", 32'(o_count), 32'd5);
    @(posedge clk); #1;
    rx_ready = 1'b0;
    @(posedge clk); #1;
    rx_data  = 8'hEE;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    cnt_chk = 1'b0;
    q.delete();
    rst = 1'b0;
    #1;
    check("mid_rst_cnt", 32'(o_count), 32'd0);
    check("mid_rst_vld", 32'(o_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b1;
    cnt_chk = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_vld", 32'(o_valid), 32'd0);
    check("post_rst_cnt", 32'(o_count), 32'd0);

    @(negedge clk);
    cnt_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
